// File: rtl/uart_byte_tx.sv
// Buffered 8N1 UART transmitter: a small byte FIFO behind a valid/ready port feeding
// a start/data/stop serialiser with a fixed bit period and back-to-back frames.
module uart_byte_tx #(
  parameter int unsigned BIT_CYCLES = 192,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_done
);

  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BCNT_W = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [1:0]        state, state_nxt;
  logic [BCNT_W-1:0] bit_cnt, bit_cnt_nxt;
  logic [2:0]        bit_idx, bit_idx_nxt;
  logic              stop_idx, stop_idx_nxt;
  logic [7:0]        shift, shift_nxt;
  logic              tx_nxt, done_nxt, busy_nxt;

  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  fifo_count, count_nxt;
  logic [7:0]        head;
  logic              push, pop;
  logic              bit_wrap, last_stop, fifo_empty;

  // Ready looks only at the registered count, so a full FIFO refuses even while popping.
  assign o_ready    = (fifo_count < CNT_W'(FIFO_DEPTH));
  assign push       = i_valid && o_ready;
  assign head       = fifo_mem[rd_ptr];
  assign fifo_empty = (fifo_count == '0);
  assign bit_wrap   = (bit_cnt == BCNT_W'(BIT_CYCLES - 1));
  assign last_stop  = (stop_idx == 1'(STOP_BITS - 1));

  // Next-state, serialiser datapath and registered-output values.
  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = '0;
    bit_idx_nxt  = bit_idx;
    stop_idx_nxt = stop_idx;
    shift_nxt    = shift;
    pop          = 1'b0;
    tx_nxt       = 1'b1;
    done_nxt     = 1'b0;

    if (state != ST_IDLE) begin
      bit_cnt_nxt = bit_wrap ? '0 : bit_cnt + BCNT_W'(1);
    end

    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_nxt = head;
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        tx_nxt = 1'b0;
        if (bit_wrap) begin
          state_nxt   = ST_DATA;
          bit_idx_nxt = '0;
        end
      end
      ST_DATA: begin
        tx_nxt = shift[0];
        if (bit_wrap) begin
          shift_nxt = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) begin
            state_nxt    = ST_STOP;
            bit_idx_nxt  = '0;
            stop_idx_nxt = 1'b0;
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
          end
        end
      end
      ST_STOP: begin
        if (bit_wrap) begin
          if (last_stop) begin
            done_nxt = 1'b1;
            // Chain straight into the next start bit so frames leave no idle gap.
            if (!fifo_empty) begin
              pop       = 1'b1;
              shift_nxt = head;
              state_nxt = ST_START;
            end else begin
              state_nxt = ST_IDLE;
            end
          end else begin
            stop_idx_nxt = stop_idx + 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    count_nxt = fifo_count;
    if (push && !pop) begin
      count_nxt = fifo_count + CNT_W'(1);
    end else if (pop && !push) begin
      count_nxt = fifo_count - CNT_W'(1);
    end

    busy_nxt = (state_nxt != ST_IDLE) || (count_nxt != '0);
  end

  // State, counters, FIFO pointers and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      shift      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      o_tx       <= 1'b1;
      o_done     <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      state      <= state_nxt;
      bit_cnt    <= bit_cnt_nxt;
      bit_idx    <= bit_idx_nxt;
      stop_idx   <= stop_idx_nxt;
      shift      <= shift_nxt;
      fifo_count <= count_nxt;
      o_tx       <= tx_nxt;
      o_done     <= done_nxt;
      o_busy     <= busy_nxt;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // Storage needs no reset; only slots between the pointers are ever read out.
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= i_data;
    end
  end

endmodule

// File: tb/tb_uart_byte_tx.sv
// Scoreboard bench for uart_byte_tx: accepted bytes are queued as expectations and a
// line monitor decodes every frame, checking level, bit timing and the done pulse.
module tb_uart_byte_tx;

  localparam int BC_A = 4;
  localparam int SB_A = 1;
  localparam int BC_B = 3;
  localparam int SB_B = 2;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       va = 1'b0, vb = 1'b0;
  logic [7:0] da = 8'h00, db = 8'h00;
  logic       ready_a, tx_a, busy_a, done_a;
  logic       ready_b, tx_b, busy_b, done_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int accept_cyc = 0;

  logic [7:0] exp_q_a[$];
  logic [7:0] exp_q_b[$];

  bit         mon_active[2] = '{1'b0, 1'b0};
  int         mon_cyc[2]    = '{0, 0};
  int         mon_bad[2]    = '{0, 0};
  logic [7:0] mon_exp[2]    = '{8'h00, 8'h00};
  logic [7:0] mon_byte[2]   = '{8'h00, 8'h00};
  int         frames[2]     = '{0, 0};
  int         dones[2]      = '{0, 0};
  int         contig[2]     = '{0, 0};
  int         stray_done[2] = '{0, 0};
  int         start_cyc[2]  = '{0, 0};
  int         done_cyc[2]   = '{0, 0};
  int         last_end[2]   = '{-10, -10};

  uart_byte_tx #(.BIT_CYCLES(BC_A), .STOP_BITS(SB_A), .FIFO_DEPTH(DEPTH)) dut_a (
    .i_clk(clk), .i_reset(rst), .i_valid(va), .i_data(da),
    .o_ready(ready_a), .o_tx(tx_a), .o_busy(busy_a), .o_done(done_a)
  );

  uart_byte_tx #(.BIT_CYCLES(BC_B), .STOP_BITS(SB_B), .FIFO_DEPTH(DEPTH)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_valid(vb), .i_data(db),
    .o_ready(ready_b), .o_tx(tx_b), .o_busy(busy_b), .o_done(done_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Per-cycle line decoder; expected byte is popped from the scoreboard at each start bit.
  task automatic mon_step(input int id, input logic tx, input logic done, input int bc,
                          input int nstop);
    int   flen;
    int   c;
    logic lvl;
    flen = (9 + nstop) * bc;
    if (rst) begin
      mon_active[id] = 1'b0;
      return;
    end
    if (!mon_active[id]) begin
      if (done) stray_done[id]++;
      if (tx == 1'b0) begin
        mon_active[id] = 1'b1;
        mon_cyc[id]    = 0;
        mon_bad[id]    = 0;
        mon_byte[id]   = 8'h00;
        start_cyc[id]  = cyc;
        if (cyc == last_end[id] + 1) contig[id]++;
        if (id == 0) begin
          check("queue_a_has_expected", exp_q_a.size() > 0 ? 1 : 0, 1);
          mon_exp[id] = (exp_q_a.size() > 0) ? exp_q_a.pop_front() : 8'h00;
        end else begin
          check("queue_b_has_expected", exp_q_b.size() > 0 ? 1 : 0, 1);
          mon_exp[id] = (exp_q_b.size() > 0) ? exp_q_b.pop_front() : 8'h00;
        end
      end
    end
    if (mon_active[id]) begin
      c = mon_cyc[id];
      if (c < bc) lvl = 1'b0;
      else if (c < 9 * bc) lvl = mon_exp[id][(c - bc) / bc];
      else lvl = 1'b1;
      if (c >= bc && c < 9 * bc && ((c - bc) % bc) == bc / 2) mon_byte[id][(c - bc) / bc] = tx;
      if (tx !== lvl) mon_bad[id]++;
      if (done) begin
        if (c != flen - 1) mon_bad[id]++;
        done_cyc[id] = cyc;
        dones[id]++;
      end else if (c == flen - 1) begin
        mon_bad[id]++;
      end
      if (c == flen - 1) begin
        frames[id]++;
        last_end[id]   = cyc;
        mon_active[id] = 1'b0;
        check($sformatf("frame_data_%0d", id), int'(mon_byte[id]), int'(mon_exp[id]));
        check($sformatf("frame_shape_%0d", id), mon_bad[id], 0);
      end
      mon_cyc[id] = c + 1;
    end
  endtask

  always @(negedge clk) begin
    mon_step(0, tx_a, done_a, BC_A, SB_A);
    mon_step(1, tx_b, done_b, BC_B, SB_B);
  end

  // Offer a byte until accepted; the expectation is queued just before the accepting edge.
  task automatic push(input int id, input logic [7:0] d, output int refused,
                      output logic done_at_acc);
    bit ok;
    ok = 1'b0;
    refused = 0;
    done_at_acc = 1'b0;
    if (id == 0) begin va = 1'b1; da = d; end
    else begin vb = 1'b1; db = d; end
    for (int k = 0; k < 3000 && !ok; k++) begin
      @(negedge clk);
      if ((id == 0) ? ready_a : ready_b) begin
        ok = 1'b1;
        done_at_acc = (id == 0) ? done_a : done_b;
        if (id == 0) exp_q_a.push_back(d);
        else exp_q_b.push_back(d);
      end else begin
        refused++;
      end
      @(posedge clk);
      #1;
      if (ok) accept_cyc = cyc;
    end
    va = 1'b0;
    vb = 1'b0;
    check("push_accepted", int'(ok), 1);
  endtask

  task automatic wait_frames(input int id, input int target, input int budget);
    for (int k = 0; k < budget && frames[id] < target; k++) @(posedge clk);
    #1;
    check($sformatf("frame_count_%0d", id), frames[id], target);
  endtask

  initial begin
    int         bad_tx, bad_rdy, bad_busy, bad_done;
    int         f0, d0, c0, acc;
    int         refused[6];
    logic       dat[6];
    logic       dummy_done;
    int         dummy_ref;
    logic [7:0] burst[6];

    burst = '{8'h00, 8'hFF, 8'h55, 8'h3C, 8'h81, 8'hC3};

    // Reset values while reset is still held.
    @(posedge clk);
    @(negedge clk);
    check("rst_tx", int'(tx_a), 1);
    check("rst_ready", int'(ready_a), 1);
    check("rst_busy", int'(busy_a), 0);
    check("rst_done", int'(done_a), 0);
    check("rst_tx_b", int'(tx_b), 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Idle for 100 cycles with no traffic.
    bad_tx = 0; bad_rdy = 0; bad_busy = 0; bad_done = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx_a !== 1'b1) bad_tx++;
      if (ready_a !== 1'b1) bad_rdy++;
      if (busy_a !== 1'b0) bad_busy++;
      if (done_a !== 1'b0) bad_done++;
    end
    check("idle_tx_high", bad_tx, 0);
    check("idle_ready", bad_rdy, 0);
    check("idle_not_busy", bad_busy, 0);
    check("idle_no_done", bad_done, 0);
    @(posedge clk);
    #1;

    // Single byte 0xA5: start bit 2 cycles after accept, done in the 40th frame cycle.
    push(0, 8'hA5, dummy_ref, dummy_done);
    acc = accept_cyc;
    wait_frames(0, 1, 200);
    check("single_start_latency", start_cyc[0] - acc, 2);
    check("single_done_offset", done_cyc[0] - start_cyc[0], 39);
    check("single_done_count", dones[0], 1);
    @(negedge clk);
    check("single_busy_after", int'(busy_a), 0);
    @(posedge clk);
    #1;

    // Two stop bits, 3-cycle bits: 33-cycle frame, done on its last cycle.
    push(1, 8'h7E, dummy_ref, dummy_done);
    wait_frames(1, 1, 200);
    check("stop2_done_offset", done_cyc[1] - start_cyc[1], 32);
    check("stop2_done_count", dones[1], 1);

    // Burst: the head pops immediately, so the sixth byte meets a full FIFO and waits
    // for the pop at the end of the first frame.
    f0 = frames[0]; d0 = dones[0]; c0 = contig[0];
    for (int i = 0; i < 6; i++) begin
      push(0, burst[i], refused[i], dat[i]);
    end
    for (int i = 0; i < 5; i++) begin
      check($sformatf("burst_ready_%0d", i), refused[i], 0);
    end
    check("burst_full_refused", refused[5] > 0 ? 1 : 0, 1);
    check("burst_accept_after_pop", int'(dat[5]), 1);
    wait_frames(0, f0 + 6, 1000);
    check("burst_done_pulses", dones[0] - d0, 6);
    check("burst_contiguous", contig[0] - c0, 5);
    check("burst_queue_drained", exp_q_a.size(), 0);
    @(negedge clk);
    check("burst_busy_after", int'(busy_a), 0);
    @(posedge clk);
    #1;

    // Reset mid-DATA with three bytes still queued.
    f0 = frames[0];
    for (int i = 0; i < 4; i++) begin
      push(0, 8'h11 + 8'(i), dummy_ref, dummy_done);
    end
    repeat (6) @(posedge clk);
    #1;
    check("pre_reset_busy", int'(busy_a), 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q_a.delete();
    @(negedge clk);
    check("abort_tx_high", int'(tx_a), 1);
    check("abort_not_busy", int'(busy_a), 0);
    check("abort_ready", int'(ready_a), 1);
    bad_tx = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx_a !== 1'b1 || busy_a !== 1'b0) bad_tx++;
    end
    check("abort_line_quiet", bad_tx, 0);
    check("abort_no_frames", frames[0], f0);
    @(posedge clk);
    #1;

    // Recovery after abort.
    push(0, 8'h5A, dummy_ref, dummy_done);
    wait_frames(0, f0 + 1, 200);
    check("stray_done_a", stray_done[0], 0);
    check("stray_done_b", stray_done[1], 0);
    check("final_queue_a", exp_q_a.size(), 0);
    check("final_queue_b", exp_q_b.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
